keypad_scanner: RTL and testbench

- Drives a 4x4 membrane keypad matrix and produces the 16 debounced, active-low key lines the calculator datapath consumes (tecla_0..tecla_9, tecla_A..tecla_D, tecla_Ast, tecla_Hash).
- Also emits a one-cycle strobe plus a 4-bit code for each newly pressed key.
- Sits between the FPGA keypad pins and the calculator top level, and is the only block that touches the raw matrix.

---
 rtl/keypad_scanner_if.sv | 44 ++++
 rtl/keypad_scanner.sv | 173 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: raw matrix pins on one side, debounced key
// lines plus new-key strobe/code on the other.
interface keypad_scanner_if;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic       tecla_0;
    logic       tecla_1;
    logic       tecla_2;
    logic       tecla_3;
    logic       tecla_4;
    logic       tecla_5;
    logic       tecla_6;
    logic       tecla_7;
    logic       tecla_8;
    logic       tecla_9;
    logic       tecla_A;
    logic       tecla_B;
    logic       tecla_C;
    logic       tecla_D;
    logic       tecla_Ast;
    logic       tecla_Hash;
    logic       key_strobe;
    logic [3:0] key_code;

    // Scanner side
    modport master (
        input  col_in,
        output row_out,
        output tecla_0, tecla_1, tecla_2, tecla_3, tecla_4,
        output tecla_5, tecla_6, tecla_7, tecla_8, tecla_9,
        output tecla_A, tecla_B, tecla_C, tecla_D, tecla_Ast, tecla_Hash,
        output key_strobe, key_code
    );

    // Pin / datapath side
    modport slave (
        output col_in,
        input  row_out,
        input  tecla_0, tecla_1, tecla_2, tecla_3, tecla_4,
        input  tecla_5, tecla_6, tecla_7, tecla_8, tecla_9,
        input  tecla_A, tecla_B, tecla_C, tecla_D, tecla_Ast, tecla_Hash,
        input  key_strobe, key_code
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner. Drives one row low at a time, samples the
// columns after a settling dwell, and after each full scan debounces the
// 16-key snapshot: a key-set change is committed only after DEBOUNCE_SCANS
// consecutive identical scans. Newly pressed keys produce a one-cycle strobe
// carrying the lowest new key code.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 5000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input logic              clk,
    input logic              rst,
    keypad_scanner_if.master kp_io
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned StbW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
    localparam logic [StbW-1:0] StableMax = StbW'(DEBOUNCE_SCANS);
    localparam logic [StbW-1:0] StableOne = StbW'(1);

    typedef enum logic {StDrive = 1'b0, StEval = 1'b1} state_e;

    // Snapshot/previous/debounced vectors are row-major: bit (row*4 + col).
    state_e            state_q, state_d;
    logic [1:0]        row_q, row_d;
    logic [DivW-1:0]   cnt_q, cnt_d;
    logic [15:0]       snap_q, snap_d;
    logic [15:0]       prev_q, prev_d;
    logic [15:0]       deb_q, deb_d;
    logic [StbW-1:0]   stable_q, stable_d;
    logic              strobe_q, strobe_d;
    logic [3:0]        code_q, code_d;

    logic [3:0]        row_drive;
    logic [15:0]       new_codes;
    logic [15:0]       deb_codes;

    // Reorder a row-major matrix vector into key-code order (bit n = code n).
    function automatic logic [15:0] to_codes(input logic [15:0] rm);
        logic [15:0] c;
        c[1]  = rm[0];
        c[2]  = rm[1];
        c[3]  = rm[2];
        c[10] = rm[3];
        c[4]  = rm[4];
        c[5]  = rm[5];
        c[6]  = rm[6];
        c[11] = rm[7];
        c[7]  = rm[8];
        c[8]  = rm[9];
        c[9]  = rm[10];
        c[12] = rm[11];
        c[14] = rm[12];
        c[0]  = rm[13];
        c[15] = rm[14];
        c[13] = rm[15];
        return c;
    endfunction

    // Index of the lowest set bit; 0 when none is set.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

    // Scan FSM, snapshot capture and debounce/commit decision.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        prev_d    = prev_q;
        deb_d     = deb_q;
        stable_d  = stable_q;
        strobe_d  = 1'b0;
        code_d    = code_q;
        row_drive = 4'b1111;
        new_codes = 16'h0000;

        unique case (state_q)
            StDrive: begin
                row_drive = ~(4'b0001 << row_q);
                if (cnt_q == DivLast) begin
                    cnt_d = '0;
                    snap_d[{row_q, 2'b00} +: 4] = ~kp_io.col_in;
                    if (row_q == 2'd3) begin
                        state_d = StEval;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEval: begin
                state_d = StDrive;
                row_d   = 2'd0;
                // A zero stable count only occurs before the first scan after reset.
                if ((snap_q != prev_q) || (stable_q == '0)) begin
                    prev_d   = snap_q;
                    stable_d = StableOne;
                end else if (stable_q < StableMax) begin
                    stable_d = stable_q + 1'b1;
                end
                if ((stable_d >= StableMax) && (snap_q != deb_q)) begin
                    deb_d     = snap_q;
                    new_codes = to_codes(snap_q & ~deb_q);
                    if (new_codes != 16'h0000) begin
                        strobe_d = 1'b1;
                        code_d   = lowest_set(new_codes);
                    end
                end
            end
        endcase
    end

    // State registers; reset discards any partial snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StDrive;
            row_q    <= 2'd0;
            cnt_q    <= '0;
            snap_q   <= 16'h0000;
            prev_q   <= 16'h0000;
            deb_q    <= 16'h0000;
            stable_q <= '0;
            strobe_q <= 1'b0;
            code_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            prev_q   <= prev_d;
            deb_q    <= deb_d;
            stable_q <= stable_d;
            strobe_q <= strobe_d;
            code_q   <= code_d;
        end
    end

    assign deb_codes = to_codes(deb_q);

    assign kp_io.row_out    = row_drive;
    assign kp_io.key_strobe = strobe_q;
    assign kp_io.key_code   = code_q;

    // Key lines are active-low copies of the registered debounced state.
    assign kp_io.tecla_0    = ~deb_codes[0];
    assign kp_io.tecla_1    = ~deb_codes[1];
    assign kp_io.tecla_2    = ~deb_codes[2];
    assign kp_io.tecla_3    = ~deb_codes[3];
    assign kp_io.tecla_4    = ~deb_codes[4];
    assign kp_io.tecla_5    = ~deb_codes[5];
    assign kp_io.tecla_6    = ~deb_codes[6];
    assign kp_io.tecla_7    = ~deb_codes[7];
    assign kp_io.tecla_8    = ~deb_codes[8];
    assign kp_io.tecla_9    = ~deb_codes[9];
    assign kp_io.tecla_A    = ~deb_codes[10];
    assign kp_io.tecla_B    = ~deb_codes[11];
    assign kp_io.tecla_C    = ~deb_codes[12];
    assign kp_io.tecla_D    = ~deb_codes[13];
    assign kp_io.tecla_Ast  = ~deb_codes[14];
    assign kp_io.tecla_Hash = ~deb_codes[15];

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical key-matrix model drives col_in from the
// set of held keys, and a scan-level reference model (history of whole-matrix
// snapshots) predicts every output each cycle.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int unsigned ScanDiv  = 4;
    localparam int unsigned DebScans = 3;
    localparam int          Period   = 4 * ScanDiv + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pressed = 16'h0000;  // bit n = key with code n held down
    logic [3:0]  col_drv;
    logic [15:0] tecla_vec;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Reference model state
    int          n_edges = 0;
    logic [15:0] cur_scan = 16'h0000;
    logic [15:0] hist[$];
    logic [15:0] m_deb = 16'h0000;
    logic        m_strobe = 1'b0;
    logic [3:0]  m_code = 4'd0;

    // DUT observation
    int          strobe_cnt = 0;
    logic [3:0]  last_code = 4'd0;
    bit          t5_low_seen = 1'b0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV       (ScanDiv),
        .DEBOUNCE_SCANS (DebScans)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .kp_io (kp)
    );

    always #5 clk = ~clk;

    assign tecla_vec = {kp.tecla_Hash, kp.tecla_Ast, kp.tecla_D, kp.tecla_C,
                        kp.tecla_B, kp.tecla_A, kp.tecla_9, kp.tecla_8,
                        kp.tecla_7, kp.tecla_6, kp.tecla_5, kp.tecla_4,
                        kp.tecla_3, kp.tecla_2, kp.tecla_1, kp.tecla_0};

    // Keypad layout: key code at (row, col).
    function automatic int code_at(input int r, input int c);
        case (r * 4 + c)
            0:  return 1;
            1:  return 2;
            2:  return 3;
            3:  return 10;
            4:  return 4;
            5:  return 5;
            6:  return 6;
            7:  return 11;
            8:  return 7;
            9:  return 8;
            10: return 9;
            11: return 12;
            12: return 14;
            13: return 0;
            14: return 15;
            default: return 13;
        endcase
    endfunction

    // Matrix: a held key pulls its column low while its row is driven low.
    always_comb begin
        col_drv = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (!kp.row_out[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[code_at(r, c)]) begin
                        col_drv[c] = 1'b0;
                    end
                end
            end
        end
    end
    assign kp.col_in = col_drv;

    function automatic logic [3:0] lowest_code(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Scan-level model: each scan samples every row once; a change commits
    // when the last DebScans scans are identical and differ from the debounced set.
    task automatic model_step();
        int  ph;
        bit  same;
        logic [15:0] newk;
        if (rst) begin
            n_edges  = 0;
            cur_scan = 16'h0000;
            hist.delete();
            m_deb    = 16'h0000;
            m_strobe = 1'b0;
            m_code   = 4'd0;
        end else begin
            ph = n_edges % Period;
            m_strobe = 1'b0;
            if (ph < 4 * ScanDiv) begin
                if ((ph % ScanDiv) == ScanDiv - 1) begin
                    for (int c = 0; c < 4; c++) begin
                        cur_scan[code_at(ph / ScanDiv, c)] = pressed[code_at(ph / ScanDiv, c)];
                    end
                end
            end else begin
                hist.push_back(cur_scan);
                if (hist.size() > DebScans) void'(hist.pop_front());
                same = (hist.size() == DebScans);
                foreach (hist[i]) if (hist[i] != cur_scan) same = 1'b0;
                if (same && (cur_scan != m_deb)) begin
                    newk = cur_scan & ~m_deb;
                    if (newk != 16'h0000) begin
                        m_strobe = 1'b1;
                        m_code   = lowest_code(newk);
                    end
                    m_deb = cur_scan;
                end
            end
            n_edges++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_row(input int n);
        int ph;
        ph = n % Period;
        if (ph < 4 * ScanDiv) return ~(4'b0001 << (ph / ScanDiv));
        return 4'b1111;
    endfunction

    // Per-cycle comparison against the model, plus DUT strobe bookkeeping.
    initial forever begin
        @(negedge clk);
        if (check_en) begin
            check("row_out", {28'd0, kp.row_out}, {28'd0, exp_row(n_edges)});
            check("tecla", {16'd0, tecla_vec}, {16'd0, ~m_deb});
            check("key_strobe", {31'd0, kp.key_strobe}, {31'd0, m_strobe});
            check("key_code", {28'd0, kp.key_code}, {28'd0, m_code});
        end
        if (kp.key_strobe === 1'b1) begin
            strobe_cnt++;
            last_code = kp.key_code;
        end
        if (kp.tecla_5 === 1'b0) t5_low_seen = 1'b1;
    end

    task automatic wait_cyc(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int  s;
        bit  found;
        logic [15:0] pk;

        #1 rst = 1'b1;
        check_en = 1'b1;
        wait_cyc(3);
        rst = 1'b0;

        // Reach row 2 of an idle scan, then reset mid-dwell
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if ((n_edges % Period) >= 2 * ScanDiv && (n_edges % Period) < 3 * ScanDiv) found = 1'b1;
        end
        check("reach_row2", {31'd0, found}, 32'd1);
        check("row2_drive", {28'd0, kp.row_out}, 32'h0000000B);
        #1 rst = 1'b1;
        pressed = 16'h0020;
        #1;
        check("rst_row_out", {28'd0, kp.row_out}, 32'h0000000E);
        check("rst_tecla", {16'd0, tecla_vec}, 32'h0000FFFF);
        check("rst_strobe", {31'd0, kp.key_strobe}, 32'd0);
        wait_cyc(2);
        rst = 1'b0;

        // Scan timing and single press '5' held from release
        s = strobe_cnt;
        for (int k = 0; k <= 52; k++) begin
            @(negedge clk);
            case (k)
                0:  check("seq_r0", {28'd0, kp.row_out}, 32'h0000000E);
                4:  check("seq_r1", {28'd0, kp.row_out}, 32'h0000000D);
                8:  check("seq_r2", {28'd0, kp.row_out}, 32'h0000000B);
                12: check("seq_r3", {28'd0, kp.row_out}, 32'h00000007);
                16: check("seq_eval", {28'd0, kp.row_out}, 32'h0000000F);
                17: check("seq_wrap", {28'd0, kp.row_out}, 32'h0000000E);
                50: check("t5_before", {31'd0, kp.tecla_5}, 32'd1);
                51: begin
                    check("t5_commit", {16'd0, tecla_vec}, 32'h0000FFDF);
                    check("t5_strobe", {31'd0, kp.key_strobe}, 32'd1);
                    check("t5_code", {28'd0, kp.key_code}, 32'd5);
                end
                52: check("t5_strobe_end", {31'd0, kp.key_strobe}, 32'd0);
                default: ;
            endcase
        end
        check("t5_strobes", strobe_cnt - s, 32'd1);
        wait_cyc(1);

        // Release: no strobe, key line returns high
        s = strobe_cnt;
        pressed = 16'h0000;
        wait_cyc(5 * Period);
        check("rel_t5", {31'd0, kp.tecla_5}, 32'd1);
        check("rel_strobes", strobe_cnt - s, 32'd0);

        // Bounce: '5' on alternating scans never commits
        s = strobe_cnt;
        t5_low_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            wait_cyc(Period);
        end
        pressed = 16'h0000;
        wait_cyc(5 * Period);
        check("bounce_t5_low", {31'd0, t5_low_seen}, 32'd0);
        check("bounce_strobes", strobe_cnt - s, 32'd0);

        // Re-press gives a fresh strobe
        s = strobe_cnt;
        pressed = 16'h0020;
        wait_cyc(5 * Period);
        check("repress_strobes", strobe_cnt - s, 32'd1);
        check("repress_code", {28'd0, last_code}, 32'd5);
        pressed = 16'h0000;
        wait_cyc(5 * Period);

        // Two keys '1' and 'A' in the same scan, then add '#'
        s = strobe_cnt;
        pressed = 16'h0402;
        wait_cyc(5 * Period);
        check("two_strobes", strobe_cnt - s, 32'd1);
        check("two_code", {28'd0, last_code}, 32'd1);
        check("two_tecla", {16'd0, tecla_vec}, 32'h0000FBFD);
        s = strobe_cnt;
        pressed = 16'h8402;
        wait_cyc(5 * Period);
        check("hash_strobes", strobe_cnt - s, 32'd1);
        check("hash_code", {28'd0, last_code}, 32'd15);
        check("hash_tecla", {16'd0, tecla_vec}, 32'h00007BFD);

        // '*' held, then reset pulsed while held
        pressed = 16'h4000;
        wait_cyc(5 * Period);
        check("ast_code", {28'd0, last_code}, 32'd14);
        rst = 1'b1;
        #1;
        check("ast_rst_tecla", {16'd0, tecla_vec}, 32'h0000FFFF);
        wait_cyc(2);
        rst = 1'b0;
        s = strobe_cnt;
        for (int k = 0; k <= 51; k++) begin
            @(negedge clk);
            if (k == 50) check("ast_before", {31'd0, kp.tecla_Ast}, 32'd1);
            if (k == 51) begin
                check("ast_recommit", {31'd0, kp.tecla_Ast}, 32'd0);
                check("ast_strobe", {31'd0, kp.key_strobe}, 32'd1);
                check("ast_recode", {28'd0, kp.key_code}, 32'd14);
            end
        end
        check("ast_strobes", strobe_cnt - s, 32'd1);
        wait_cyc(1);

        // Randomized key sets and hold times, checked by the model every cycle
        for (int seg = 0; seg < 40; seg++) begin
            pk = 16'h0000;
            for (int j = 0; j < $urandom_range(0, 3); j++) begin
                pk[$urandom_range(0, 15)] = 1'b1;
            end
            pressed = pk;
            wait_cyc($urandom_range(5, 90));
        end
        pressed = 16'h0000;
        wait_cyc(5 * Period);
        check("final_idle", {16'd0, tecla_vec}, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
